sdcntr_ld: RTL
==============

// Module: sdcntr_ld
// PURPOSE
//  Synchronous loadable down counter: the count-down companion to the datapath up-counter.
//  Counts from a loaded value toward zero. Drives a combinational borrow-out (BOUT) so stages cascade like the up-counter's COUT.
//  Three terminal-count modes: wrap, auto-reload, one-shot.
//  Sits in datapath groups as a timer/divider/loop-count source.
// PARAMETERS
//  N         8         counter / load width
//  DPFLAG    1         datapath placement flag (passed through, no functional effect)
//  GROUP     "dpath1"  datapath group name (passed through)
//  d_BOUT_r  1         BOUT rise delay
//  d_BOUT_f  1         BOUT fall delay
//  d_TC      1         TC output delay
//  d_Q       1         Q / ZERO output delay
// PORTS
//  CLK   in   1    clock, rising edge active
//  CLR   in   1    asynchronous active-low reset
//  LD    in   1    synchronous load of D into Q and reload register RV
//  D     in   N    load value
//  EN    in   1    count enable
//  BIN   in   1    borrow-in from lower cascade stage (tie 1 if unused)
//  MODE  in   2    00 wrap, 01 auto-reload, 10 one-shot, 11 = wrap
//  Q     out  N    current count
//  ZERO  out  1    Q == 0 (combinational from state)
//  BOUT  out  1    EN & BIN & (Q == 0), combinational, for cascading
//  TC    out  1    registered terminal-count pulse
// BEHAVIOUR
//  - Reset: CLR low -> Q=0, RV=0, TC=0 immediately, independent of CLK.
//    Outputs while CLR low: ZERO=1, BOUT=EN&BIN.
//  - Count event CE = EN & BIN & ~LD.
//  - Per rising CLK, priority order:
//    1. LD=1: Q<=D, RV<=D, TC<=0. EN, BIN and MODE are ignored.
//    2. CE=1 and Q!=0: Q<=Q-1 (mod 2^N), TC<=0.
//    3. CE=1 and Q==0 (borrow event): TC<=1, and
//       MODE 00/11: Q<=all ones (wrap);
//       MODE 01: Q<=RV (RV==0 -> Q stays 0, TC pulses every CE);
//       MODE 10: Q holds 0. TC pulses on the first borrow only; the pulse is
//       rearmed only by LD (track with 1-bit flag OS_DONE, cleared by LD/CLR).
//    4. Otherwise: Q, RV hold; TC<=0.
//  - TC is a 1-cycle pulse, visible the cycle after the borrow event, coincident with the reloaded/wrapped Q.
//  - Latency: LD/count -> Q in 1 clock. BOUT/ZERO have zero latency from Q/EN/BIN.
//  - MODE may change any cycle; it takes effect at the next borrow event. RV is unaffected.
//  - CLR deassertion is synchronous-safe: the first edge after release acts normally.
//  - No arithmetic beyond N bits; the decrement wraps naturally mod 2^N.
// STRUCTURE
//  - Shared package sdcntr_pkg: MODE_WRAP=2'b00, MODE_RELOAD=2'b01,
//    MODE_ONESHOT=2'b10 constants; N-wide zero/ones helper constants.
//  - One sub-module: sdcntr_generic (state regs Q/RV/OS_DONE/TC, next-state logic).
//  - Top level: input/output delay assigns around sdcntr_generic, plus specify checks:
//    $width(negedge CLR), and $setup/$hold of EN, LD, D vs posedge CLK.
// TESTING
//  1. CLR low mid-count (Q=0x5A) -> Q=0, TC=0 without a clock edge; ZERO=1.
//  2. LD D=3, MODE=00, EN=BIN=1 -> Q sequence 3,2,1,0,FF,FE.
//     BOUT high in the Q=0 cycle; TC=1 in the Q=FF cycle only.
//  3. LD D=2, MODE=01 -> Q sequence 2,1,0,2,1,0,2.
//     TC=1 in each cycle Q returns to 2; EN=0 for 3 cycles freezes Q.
//  4. LD D=1, MODE=10 -> Q sequence 1,0,0,0.
//     A single TC pulse, ZERO=1 held; LD D=1 rearms and a second TC follows.
//  5. LD=1 and EN=1 with Q=0 in the same cycle, D=7 -> Q=7, TC=0 (load wins).
//  6. Two 4-bit stages (upper BIN = lower BOUT), both loaded 0 -> counts 0x00,0xFF,0xFE.
//     Upper BOUT high only at combined 0x00.

Source files
------------

// File: rtl/sdcntr_pkg.sv
// Shared constants for the sdcntr family of datapath counters.
// Terminal-count mode encodings and default-width helper values.
package sdcntr_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam int unsigned DEF_N = 8;

    localparam logic [DEF_N-1:0] CNT_ZERO = '0;
    localparam logic [DEF_N-1:0] CNT_ONES = '1;

endpackage

// File: rtl/sdcntr_generic.sv
// Loadable down-counter core: count, reload and one-shot state plus next-state logic.
// Borrow-out and zero flag are combinational from state so stages can cascade.
module sdcntr_generic
    import sdcntr_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         bin,
    input  logic [1:0]   mode,
    output logic [N-1:0] q,
    output logic         zero,
    output logic         bout,
    output logic         tc
);

    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rv_q, rv_d;
    logic         os_done_q, os_done_d;
    logic         tc_q, tc_d;
    logic         ce;
    logic         q_is_zero;

    assign q_is_zero = (q_q == '0);
    assign ce        = en & bin & ~ld;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q       <= '0;
            rv_q      <= '0;
            os_done_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            q_q       <= q_d;
            rv_q      <= rv_d;
            os_done_q <= os_done_d;
            tc_q      <= tc_d;
        end
    end

    always_comb begin
        q_d       = q_q;
        rv_d      = rv_q;
        os_done_d = os_done_q;
        tc_d      = 1'b0;
        if (ld) begin
            q_d       = d;
            rv_d      = d;
            os_done_d = 1'b0;
        end else if (ce && !q_is_zero) begin
            q_d = q_q - 1'b1;
        end else if (ce) begin
            // Borrow event: mode only matters here, so mid-count MODE changes are harmless.
            case (mode)
                MODE_RELOAD: begin
                    q_d  = rv_q;
                    tc_d = 1'b1;
                end
                MODE_ONESHOT: begin
                    q_d       = '0;
                    tc_d      = ~os_done_q;
                    os_done_d = 1'b1;
                end
                default: begin
                    q_d  = '1;
                    tc_d = 1'b1;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign zero = q_is_zero;
    assign bout = en & bin & q_is_zero;
    assign tc   = tc_q;

endmodule

// File: rtl/sdcntr_ld.sv
// Datapath-level wrapper for the loadable down counter.
// Placement and timing parameters are carried for back-annotation only; the logic is zero-delay.
module sdcntr_ld
    import sdcntr_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned DPFLAG   = 1,
    parameter string       GROUP    = "dpath1",
    parameter int unsigned d_BOUT_r = 1,
    parameter int unsigned d_BOUT_f = 1,
    parameter int unsigned d_TC     = 1,
    parameter int unsigned d_Q      = 1
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         LD,
    input  logic [N-1:0] D,
    input  logic         EN,
    input  logic         BIN,
    input  logic [1:0]   MODE,
    output logic [N-1:0] Q,
    output logic         ZERO,
    output logic         BOUT,
    output logic         TC
);

    localparam int unsigned DelaySum = d_BOUT_r + d_BOUT_f + d_TC + d_Q + DPFLAG;

    if (N == 0 || DelaySum > 32'h0000_ffff || GROUP == "") begin : g_bad_params
        $error("sdcntr_ld: invalid parameter set");
    end

    logic [N-1:0] d_in;
    logic         ld_in, en_in, bin_in;
    logic [1:0]   mode_in;
    logic [N-1:0] q_out;
    logic         zero_out, bout_out, tc_out;

    assign ld_in   = LD;
    assign d_in    = D;
    assign en_in   = EN;
    assign bin_in  = BIN;
    assign mode_in = MODE;

    sdcntr_generic #(
        .N (N)
    ) u_core (
        .clk  (CLK),
        .clr  (CLR),
        .ld   (ld_in),
        .d    (d_in),
        .en   (en_in),
        .bin  (bin_in),
        .mode (mode_in),
        .q    (q_out),
        .zero (zero_out),
        .bout (bout_out),
        .tc   (tc_out)
    );

    assign Q    = q_out;
    assign ZERO = zero_out;
    assign BOUT = bout_out;
    assign TC   = tc_out;

endmodule
